// File: rtl/aes_inv_key_expansion_pkg.sv
// rtl/aes_inv_key_expansion_pkg.sv - shared constants, state enum and word helpers for inverse AES-128 key expansion
package aes_inv_key_expansion_pkg;

  localparam int         NR            = 10;
  localparam logic [7:0] RCON_LAST     = 8'h36;
  localparam logic [7:0] INV_RCON_POLY = 8'h8D;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Rotate a key word left by one byte.
  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

  // Step the round constant backwards: divide by x in GF(2^8).
  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    return x[0] ? ((x >> 1) ^ INV_RCON_POLY) : (x >> 1);
  endfunction

endpackage

// File: rtl/aes_sbox_word.sv
// rtl/aes_sbox_word.sv - SubWord: four forward AES S-box lookups on a 32-bit word
module aes_sbox_word (
  input  logic [31:0] in_word,
  output logic [31:0] out_word
);

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // S-box computed as the multiplicative inverse (x^254, so 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] pw;
    logic [7:0] inv;
    pw  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Byte-wise substitution of the whole word.
  always_comb begin
    out_word = '0;
    for (int i = 0; i < 4; i++) begin
      out_word[8*i +: 8] = sbox(in_word[8*i +: 8]);
    end
  end

endmodule

// File: rtl/aes_inv_key_expansion.sv
// rtl/aes_inv_key_expansion.sv - walks AES-128 round keys backwards from the final key, one per cycle
module aes_inv_key_expansion
  import aes_inv_key_expansion_pkg::*;
#(
  parameter int NR = aes_inv_key_expansion_pkg::NR
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         flush,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [127:0] last_key,
  output logic         key_valid,
  input  logic         key_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         busy
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   idx_q, idx_d;
  logic [7:0]   rcon_q, rcon_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  w0_prev, w1_prev, w2_prev, w3_prev;
  logic [31:0]  sub_in, sub_out;
  logic [127:0] prev_key;

  aes_sbox_word u_sbox (
    .in_word  (sub_in),
    .out_word (sub_out)
  );

  // Undo one round of forward expansion; w3 is recovered first because w0 depends on it.
  always_comb begin
    w0      = key_q[127:96];
    w1      = key_q[95:64];
    w2      = key_q[63:32];
    w3      = key_q[31:0];
    w3_prev = w3 ^ w2;
    w2_prev = w2 ^ w1;
    w1_prev = w1 ^ w0;
    sub_in  = rot_word(w3_prev);
    w0_prev = w0 ^ sub_out ^ {rcon_q, 24'h0};
    prev_key = {w0_prev, w1_prev, w2_prev, w3_prev};
  end

  // Next-state: flush wins over any handshake and leaves the datapath registers untouched.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            key_d   = last_key;
            idx_d   = LAST_IDX;
            rcon_d  = RCON_LAST;
            state_d = EMIT;
          end
        end
        EMIT: begin
          if (key_ready) begin
            if (idx_q != 4'd0) begin
              key_d  = prev_key;
              idx_d  = idx_q - 4'd1;
              rcon_d = inv_xtime(rcon_q);
            end else begin
              state_d = IDLE;
            end
          end
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      rcon_q  <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
    end
  end

  assign load_ready = (state_q == IDLE);
  assign key_valid  = (state_q == EMIT);
  assign busy       = (state_q == EMIT);
  assign round_key  = key_q;
  assign round_idx  = idx_q;

endmodule
